// File: rtl/seven_segment_decoder.sv
// Reads a 7-segment drive pattern back into a 4-bit value after it has held steady.
// Define SEG_DECODE_HEX_EN to also accept the A-F glyphs as valid digits.
module seven_segment_decoder #(
  parameter int STABLE_CYCLES       = 250000,
  parameter int ACTIVE_LOW_SEGMENTS = 1
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Segment_A,
  input  logic       i_Segment_B,
  input  logic       i_Segment_C,
  input  logic       i_Segment_D,
  input  logic       i_Segment_E,
  input  logic       i_Segment_F,
  input  logic       i_Segment_G,
  output logic [3:0] o_Binary_Num,
  output logic       o_Valid,
  output logic       o_Blank,
  output logic       o_Error,
  output logic       o_Change_Pulse,
  output logic [7:0] o_Change_Count
);

  localparam int CW = 21;
  localparam logic [6:0] SYNC_IDLE = (ACTIVE_LOW_SEGMENTS != 0) ? 7'h7F : 7'h00;

  typedef enum logic [1:0] {SETTLE, ACCEPT, LOCKED} state_t;

  state_t          r_State, w_Next_State;
  logic [CW-1:0]   r_Count, w_Next_Count, w_Count_Inc;
  logic [6:0]      w_Raw, r_Sync1, r_Sync2, w_P, r_Prev, r_Ref;
  logic            w_Changed, w_Reached;
  logic [4:0]      w_Dec;

  function automatic logic [4:0] f_decode(input logic [6:0] p);
    logic [4:0] d;
    case (p)
      7'h7E:   d = {1'b1, 4'h0};
      7'h30:   d = {1'b1, 4'h1};
      7'h6D:   d = {1'b1, 4'h2};
      7'h79:   d = {1'b1, 4'h3};
      7'h33:   d = {1'b1, 4'h4};
      7'h5B:   d = {1'b1, 4'h5};
      7'h5F:   d = {1'b1, 4'h6};
      7'h70:   d = {1'b1, 4'h7};
      7'h7F:   d = {1'b1, 4'h8};
      7'h7B:   d = {1'b1, 4'h9};
`ifdef SEG_DECODE_HEX_EN
      7'h77:   d = {1'b1, 4'hA};
      7'h1F:   d = {1'b1, 4'hB};
      7'h4E:   d = {1'b1, 4'hC};
      7'h3D:   d = {1'b1, 4'hD};
      7'h4F:   d = {1'b1, 4'hE};
      7'h47:   d = {1'b1, 4'hF};
`endif
      default: d = {1'b0, 4'h0};
    endcase
    return d;
  endfunction

  assign w_Raw       = {i_Segment_A, i_Segment_B, i_Segment_C, i_Segment_D,
                        i_Segment_E, i_Segment_F, i_Segment_G};
  assign w_P         = (ACTIVE_LOW_SEGMENTS != 0) ? ~r_Sync2 : r_Sync2;
  assign w_Changed   = (w_P != r_Prev);
  assign w_Count_Inc = w_Changed ? '0 : r_Count + 1'b1;
  assign w_Reached   = (w_Count_Inc >= CW'(STABLE_CYCLES - 1));
  // r_Prev holds the settled pattern during the ACCEPT cycle
  assign w_Dec       = f_decode(r_Prev);

  // A change seen in ACCEPT restarts settling immediately so it is never lost
  always_comb begin
    w_Next_State = r_State;
    w_Next_Count = r_Count;
    case (r_State)
      SETTLE: begin
        w_Next_Count = w_Count_Inc;
        if (w_Reached) w_Next_State = ACCEPT;
      end
      ACCEPT, LOCKED: begin
        if (w_Changed) begin
          w_Next_Count = '0;
          w_Next_State = w_Reached ? ACCEPT : SETTLE;
        end else begin
          w_Next_State = LOCKED;
        end
      end
      default: begin
        w_Next_State = SETTLE;
        w_Next_Count = '0;
      end
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_Sync1        <= SYNC_IDLE;
      r_Sync2        <= SYNC_IDLE;
      r_Prev         <= '0;
      r_Ref          <= '0;
      r_State        <= SETTLE;
      r_Count        <= '0;
      o_Binary_Num   <= '0;
      o_Valid        <= 1'b0;
      o_Blank        <= 1'b1;
      o_Error        <= 1'b0;
      o_Change_Pulse <= 1'b0;
      o_Change_Count <= '0;
    end else begin
      r_Sync1        <= w_Raw;
      r_Sync2        <= r_Sync1;
      r_Prev         <= w_P;
      r_State        <= w_Next_State;
      r_Count        <= w_Next_Count;
      o_Change_Pulse <= 1'b0;
      if (r_State == ACCEPT) begin
        if (w_Dec[4]) begin
          o_Binary_Num <= w_Dec[3:0];
          o_Valid      <= 1'b1;
          o_Blank      <= 1'b0;
          o_Error      <= 1'b0;
        end else if (r_Prev == 7'h00) begin
          o_Valid <= 1'b0;
          o_Blank <= 1'b1;
          o_Error <= 1'b0;
        end else begin
          o_Valid <= 1'b0;
          o_Blank <= 1'b0;
          o_Error <= 1'b1;
        end
        if (r_Prev != r_Ref) begin
          o_Change_Pulse <= 1'b1;
          o_Change_Count <= o_Change_Count + 8'd1;
          r_Ref          <= r_Prev;
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Scoreboard bench for seven_segment_decoder: a segment-level model predicts each
// acceptance; a monitor compares the outputs every cycle against the expectations.
module tb_seven_segment_decoder;
  localparam int S  = 4;
  localparam int AL = 1;

  logic       clk = 1'b0;
  logic       rst_l;
  logic [6:0] pins;
  logic [3:0] num;
  logic       valid, blank, error, pulse;
  logic [7:0] ccount;

  always #5 clk = ~clk;

  seven_segment_decoder #(.STABLE_CYCLES(S), .ACTIVE_LOW_SEGMENTS(AL)) dut (
    .i_Clk(clk), .i_Rst_L(rst_l),
    .i_Segment_A(pins[6]), .i_Segment_B(pins[5]), .i_Segment_C(pins[4]),
    .i_Segment_D(pins[3]), .i_Segment_E(pins[2]), .i_Segment_F(pins[1]),
    .i_Segment_G(pins[0]),
    .o_Binary_Num(num), .o_Valid(valid), .o_Blank(blank), .o_Error(error),
    .o_Change_Pulse(pulse), .o_Change_Count(ccount)
  );

  typedef struct {
    int         t;
    logic [3:0] num;
    logic       valid, blank, error, pulse;
    logic [7:0] cnt;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   chk_en = 1'b0;

  logic [6:0] seg_tab [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                               7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
`ifdef SEG_DECODE_HEX_EN
  localparam int NUM_LEGAL = 16;
`else
  localparam int NUM_LEGAL = 10;
`endif

  // Model state: accepted outputs plus the pin-level segment currently held
  logic [3:0] m_num;
  logic [7:0] m_cnt;
  logic [6:0] m_ref;
  logic [6:0] cur_pat;
  int         cur_start, cur_end;
  bit         cur_acc;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lookup(input logic [6:0] p);
    for (int i = 0; i < NUM_LEGAL; i++) if (seg_tab[i] == p) return i;
    return -1;
  endfunction

  task automatic push_accept(input logic [6:0] p, input int t);
    exp_t e;
    int   k;
    k = lookup(p);
    e.t = t;
    e.valid = (k >= 0);
    e.blank = (k < 0) && (p == 7'h00);
    e.error = (k < 0) && (p != 7'h00);
    if (k >= 0) m_num = 4'(k);
    e.num   = m_num;
    e.pulse = (p != m_ref);
    if (e.pulse) begin
      m_cnt = m_cnt + 8'd1;
      m_ref = p;
    end
    e.cnt = m_cnt;
    q.push_back(e);
  endtask

  // Pins change #1 after edge cyc; a run of S cycles is accepted at start+S+3.
  task automatic apply(input logic [6:0] p, input int h);
    int t;
    t = cyc;
    pins = (AL != 0) ? ~p : p;
    if (p != cur_pat) begin
      cur_pat   = p;
      cur_start = t;
      cur_acc   = 1'b0;
    end
    cur_end = t + h;
    if (!cur_acc && (cur_end - cur_start) >= S) begin
      push_accept(p, cur_start + S + 3);
      cur_acc = 1'b1;
    end
    repeat (h) @(posedge clk);
    #1;
  endtask

  // After reset the synchroniser reads blank, as if blank pins arrived 3 cycles earlier.
  task automatic do_reset(input int n);
    exp_t e;
    chk_en = 1'b0;
    rst_l  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst_l = 1'b1;
    m_num = '0; m_cnt = '0; m_ref = '0;
    cur_pat = '0; cur_start = cyc - 3; cur_end = cyc; cur_acc = 1'b0;
    e.t = cyc; e.num = '0; e.valid = 1'b0; e.blank = 1'b1; e.error = 1'b0;
    e.pulse = 1'b0; e.cnt = '0;
    q.push_back(e);
    chk_en = 1'b1;
  endtask

  task automatic chk(input string name, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, expv);
    end
  endtask

  exp_t hold;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("onehot", int'(valid) + int'(blank) + int'(error), 1);
      if (q.size() > 0 && q[0].t == cyc) begin
        hold = q.pop_front();
        chk("accept_pulse", int'(pulse), int'(hold.pulse));
      end else begin
        chk("idle_pulse", int'(pulse), 0);
      end
      chk("num",   int'(num),    int'(hold.num));
      chk("valid", int'(valid),  int'(hold.valid));
      chk("blank", int'(blank),  int'(hold.blank));
      chk("error", int'(error),  int'(hold.error));
      chk("count", int'(ccount), int'(hold.cnt));
    end
  end

  initial begin
    rst_l = 1'b0;
    pins  = (AL != 0) ? 7'h7F : 7'h00;
    @(posedge clk); #1;
    do_reset(3);

    // digit 3, then a short glitch to 8 and back
    apply(7'h79, 12);
    apply(7'h7F, 2);
    apply(7'h79, 10);

    // sweep 0..9, then repeat 9
    for (int d = 0; d < 10; d++) apply(seg_tab[d], 10);
    apply(seg_tab[9], 10);

    // hex glyph A
    apply(7'h77, 10);

    // blank after reset, then an illegal pattern
    do_reset(2);
    apply(7'h00, 10);
    apply(7'h01, 10);

    // reset mid-settle, then a held pattern
    apply(7'h30, 10);
    apply(7'h6D, 3);
    do_reset(1);
    apply(7'h5B, 12);

    // 256 changes wrap the counter
    do_reset(1);
    for (int i = 0; i < 256; i++) apply((i % 2 == 0) ? 7'h6D : 7'h30, S + 1);
    apply(7'h6D, 10);

    // random patterns with random hold times, including sub-threshold glitches
    for (int i = 0; i < 300; i++) begin
      logic [6:0] p;
      int r;
      r = int'($urandom % 10);
      if (r < 6)       p = seg_tab[$urandom % 16];
      else if (r == 6) p = 7'h00;
      else             p = 7'($urandom);
      apply(p, int'($urandom_range(1, 2 * S + 2)));
    end
    apply(7'h7E, 20);

    for (int i = 0; i < 100 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations pending, expected 0", q.size());
    end
    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
